md_unit: RTL and testbench

- Iterative multiply/divide responder for the execute stage of the five-stage MIPS pipeline.
- Execute-stage control issues a one-cycle start with operands; this block owns the HI/LO registers and holds busy for a fixed latency.
- Drives a stall request that the hazard unit uses to freeze the pipeline while MFHI/MFLO/MTHI/MTLO/mult/div wait.
- The result feeds back into execute-stage result selection.

---
 rtl/md_pkg.sv | 40 ++++
 rtl/md_divider.sv | 24 ++
 rtl/md_unit.sv | 107 ++++++++++
 tb/tb_md_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op encoding, FSM states, latency defaults and op-class helpers for md_unit (MD_MADD_EN enables MADD/MADDU)
package md_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Multiply-class ops; MADD/MADDU only exist when accumulation is built in
    function automatic logic md_is_mul(input md_op_e op);
`ifdef MD_MADD_EN
        return op == OP_MULT || op == OP_MULTU || op == OP_MADD || op == OP_MADDU;
`else
        return op == OP_MULT || op == OP_MULTU;
`endif
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: combinational signed/unsigned quotient/remainder with divide-by-zero flag
module md_divider (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem,
    output logic        o_div0
);
    logic        w_na, w_nb;
    logic [31:0] w_ma, w_mb, w_q, w_r;

    // Divide magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
    assign w_na   = i_signed & i_a[31];
    assign w_nb   = i_signed & i_b[31];
    assign w_ma   = w_na ? -i_a : i_a;
    assign w_mb   = w_nb ? -i_b : i_b;
    assign o_div0 = (i_b == 32'd0);
    assign w_q    = o_div0 ? 32'd0 : w_ma / w_mb;
    assign w_r    = o_div0 ? 32'd0 : w_ma % w_mb;
    assign o_quo  = (w_na ^ w_nb) ? -w_q : w_q;
    assign o_rem  = w_na ? -w_r : w_r;
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative-latency MIPS multiply/divide unit owning HI/LO (MD_MADD_EN enables MADD/MADDU accumulate)
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo,
    output logic [31:0] md_rdata
);
    md_state_e   r_state;
    logic        r_busy;
    logic [31:0] r_cnt;
    logic [31:0] r_hi, r_lo, r_sh_hi, r_sh_lo;

    md_op_e      w_op;
    logic        w_mul_go, w_div_go, w_uns, w_div0;
    logic [63:0] w_prod, w_mul_res, w_div_res;
    logic [31:0] w_quo, w_rem;

    assign w_op     = md_op_e'(md_op);
    assign w_mul_go = md_is_mul(w_op);
    assign w_div_go = md_is_div(w_op);
    assign w_uns    = (w_op == OP_MULTU) || (w_op == OP_MADDU);

    // Sign-extending to 64 bits and multiplying gives the signed product modulo 2^64
    assign w_prod = w_uns ? {32'd0, md_a} * {32'd0, md_b}
                          : {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};

`ifdef MD_MADD_EN
    assign w_mul_res = w_prod + (((w_op == OP_MADD) || (w_op == OP_MADDU)) ? {r_hi, r_lo} : 64'd0);
`else
    assign w_mul_res = w_prod;
`endif

    md_divider u_div (
        .i_a      (md_a),
        .i_b      (md_b),
        .i_signed (w_op == OP_DIV),
        .o_quo    (w_quo),
        .o_rem    (w_rem),
        .o_div0   (w_div0)
    );

    // Divide by zero keeps HI/LO by committing their current values after the full latency
    assign w_div_res = w_div0 ? {r_hi, r_lo} : {w_rem, w_quo};

    // Start/countdown/commit FSM; shadow result is computed at the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        if (w_mul_go) begin
                            r_state              <= S_MUL;
                            r_busy               <= 1'b1;
                            r_cnt                <= 32'(MULT_CYCLES - 1);
                            {r_sh_hi, r_sh_lo}   <= w_mul_res;
                        end else if (w_div_go) begin
                            r_state              <= S_DIV;
                            r_busy               <= 1'b1;
                            r_cnt                <= 32'(DIV_CYCLES - 1);
                            {r_sh_hi, r_sh_lo}   <= w_div_res;
                        end else if (w_op == OP_MTHI) begin
                            r_hi <= md_a;
                        end else if (w_op == OP_MTLO) begin
                            r_lo <= md_a;
                        end
                    end
                end
                default: begin
                    if (r_cnt == 32'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_hi    <= r_sh_hi;
                        r_lo    <= r_sh_lo;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
            endcase
        end
    end

    assign md_busy  = r_busy;
    assign md_stall = r_busy | (md_start & (w_mul_go | w_div_go));
    assign md_hi    = r_hi;
    assign md_lo    = r_lo;
    assign md_rdata = (w_op == OP_MFHI) ? r_hi : (w_op == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit latency, arithmetic, MTHI/MTLO, reset and optional MADD
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] md_a = 32'd0, md_b = 32'd0;
    logic        md_busy, md_stall;
    logic [31:0] md_hi, md_lo, md_rdata;

    int n_checks = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    md_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_hi    (md_hi),
        .md_lo    (md_lo),
        .md_rdata (md_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic is_class(input logic [3:0] op);
`ifdef MD_MADD_EN
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
`else
        return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
    endfunction

    // Drive a one-cycle start; returns 1ns after the start edge with start low
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        #1;
        chk($sformatf("stall_start_op%0d", op), 64'(md_stall), 64'(is_class(op)));
        @(posedge clk); #1;
        md_start = 1'b0; md_op = 4'd0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n_exp, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inject);
        int n;
        logic [63:0] e;
        sb.push_back({exp_hi, exp_lo});
        issue(op, a, b);
        n = 0;
        while (md_busy && n < 200) begin
            if (n == 1) chk({tag, "_stall_busy"}, 64'(md_stall), 64'd1);
            if (inject && n == 2) begin
                md_start = 1'b1; md_op = 4'd4; md_a = 32'd1; md_b = 32'd1;
            end else begin
                md_start = 1'b0; md_op = 4'd0;
            end
            @(posedge clk); #1;
            n++;
        end
        md_start = 1'b0; md_op = 4'd0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(n_exp));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(md_hi), 64'(e[63:32]));
            chk({tag, "_lo"}, 64'(md_lo), 64'(e[31:0]));
            md_op = 4'd5; #1;
            chk({tag, "_mfhi"}, 64'(md_rdata), 64'(e[63:32]));
            md_op = 4'd0;
        end
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_hi", 64'(md_hi), 64'd0);
        chk("rst_lo", 64'(md_lo), 64'd0);
        chk("rst_rdata", 64'(md_rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 0);
        run_op("mtlo0", 4'd8, 32'd0, 32'd0, 0, 32'd1, 32'd0, 0);
        run_op("mthi", 4'd7, 32'h12345678, 32'd0, 0, 32'h12345678, 32'd0, 0);
        run_op("divu0", 4'd4, 32'd5, 32'd0, 10, 32'h12345678, 32'd0, 0);
        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 0);
        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1);
        run_op("invalid", 4'd15, 32'hDEADBEEF, 32'd3, 0, 32'hFFFFFFFE, 32'h00000001, 0);

        issue(4'd3, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 64'(md_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(md_busy), 64'd0);
        chk("async_rst_hi", 64'(md_hi), 64'd0);
        chk("async_rst_lo", 64'(md_lo), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult23", 4'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6, 0);
        md_op = 4'd6; #1;
        chk("mflo", 64'(md_rdata), 64'd6);
        md_op = 4'd0;
        run_op("mtlo10", 4'd8, 32'd10, 32'd0, 0, 32'd0, 32'd10, 0);
`ifdef MD_MADD_EN
        run_op("madd", 4'd9, 32'd2, 32'd3, 5, 32'd0, 32'd16, 0);
`else
        run_op("madd_off", 4'd9, 32'd2, 32'd3, 0, 32'd0, 32'd10, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
